fetch_stall_ctrl: RTL

//  Sequences the IF/ID pipeline register and the PC: decides each cycle whether to

---
 rtl/fetch_stall_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage advance/stall/squash sequencer for the PC and IF/ID register.
// Optional cycle-stall counter enabled by defining FETCH_STALL_PERF_EN.
module fetch_stall_ctrl #(
  parameter logic [15:0] NOP_INSTR    = 16'h0800,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          MAX_MEM_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic        ldu_hazard,
  input  logic        halt,
  output logic        pc_write_en,
  output logic        ifid_write_en,
  output logic        ifid_flush,
  output logic [15:0] nop_instr,
  output logic        idex_bubble,
  output logic [1:0]  state,
`ifdef FETCH_STALL_PERF_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [2:0] FRELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WMAX    = 8'(MAX_MEM_WAIT);

  state_t     st, st_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       err_nxt;

  assign nop_instr = NOP_INSTR;
  assign state     = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= RUN;
      fcnt <= '0;
      wcnt <= '0;
      err  <= 1'b0;
    end else begin
      st   <= st_nxt;
      fcnt <= fcnt_nxt;
      wcnt <= wcnt_nxt;
      err  <= err_nxt;
    end
  end

  always_comb begin
    st_nxt        = st;
    fcnt_nxt      = fcnt;
    wcnt_nxt      = wcnt;
    err_nxt       = err;
    pc_write_en   = 1'b0;
    ifid_write_en = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    unique case (st)
      RUN: begin
        if (redirect) begin
          pc_write_en   = 1'b1;
          ifid_write_en = 1'b1;
          ifid_flush    = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            st_nxt   = FLUSH;
            fcnt_nxt = FRELOAD;
          end
        end else if (imem_stall) begin
          ifid_flush = 1'b1;
          st_nxt     = MEM_WAIT;
          wcnt_nxt   = 8'd1;
        end else if (ldu_hazard) begin
          idex_bubble = 1'b1;
        end else if (halt) begin
          st_nxt = HALT;
        end else begin
          pc_write_en   = 1'b1;
          ifid_write_en = 1'b1;
        end
      end
      FLUSH: begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        if (redirect) begin
          fcnt_nxt = FRELOAD;
        end else begin
          fcnt_nxt = fcnt - 3'd1;
          if (fcnt <= 3'd1) st_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (redirect) begin
          // A taken branch makes the outstanding fetch irrelevant.
          pc_write_en   = 1'b1;
          ifid_write_en = 1'b1;
          ifid_flush    = 1'b1;
          wcnt_nxt      = '0;
          if (FLUSH_CYCLES > 1) begin
            st_nxt   = FLUSH;
            fcnt_nxt = FRELOAD;
          end else begin
            st_nxt = RUN;
          end
        end else begin
          idex_bubble = 1'b1;
          if (imem_done) begin
            st_nxt   = RUN;
            wcnt_nxt = '0;
          end else if (wcnt == WMAX) begin
            err_nxt = 1'b1;
            st_nxt  = HALT;
          end else if (wcnt != 8'hFF) begin
            wcnt_nxt = wcnt + 8'd1;
          end
        end
      end
      HALT: begin
        if (redirect) err_nxt = 1'b1;
      end
      default: st_nxt = RUN;
    endcase
    if (rst) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
    end
  end

`ifdef FETCH_STALL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!ifid_write_en && st != HALT
                 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
